// File: rtl/auteur_pkg.sv
// -----------------------------------------------------------------------------
// auteur_pkg
// Shared definitions for the auteur dot-product accumulation stage:
//   - default widths for the partial sum, accumulator mantissa and exponent
//   - output-side FSM state encoding
//   - exponent renormalisation helpers (increment with saturation at the
//     largest signed value representable in a given width)
// No ports (package).
// -----------------------------------------------------------------------------
package auteur_pkg;

  localparam int unsigned sum_width_default = 24;
  localparam int unsigned acc_width_default = 32;
  localparam int unsigned exp_width_default = 10;

  // Output register occupancy.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Largest signed value of a 'width'-bit exponent, held in a 32-bit container.
  function automatic logic signed [31:0] exp_max(input int unsigned width);
    return (32'sd1 <<< (width - 1)) - 32'sd1;
  endfunction

  // Exponent after an optional single-bit renormalisation. An increment that
  // would pass the largest signed value sticks at that value instead.
  function automatic logic signed [31:0] renorm_exp(input logic signed [31:0] exp_in,
                                                    input logic               inc,
                                                    input int unsigned        width);
    if (!inc) begin
      return exp_in;
    end
    if (exp_in >= exp_max(width)) begin
      return exp_max(width);
    end
    return exp_in + 32'sd1;
  endfunction

  // High when renorm_exp() had to saturate.
  function automatic logic renorm_sat(input logic signed [31:0] exp_in,
                                      input logic               inc,
                                      input int unsigned        width);
    return inc && (exp_in >= exp_max(width));
  endfunction

endpackage

// File: rtl/auteur_dotp_acc_if.sv
// -----------------------------------------------------------------------------
// auteur_dotp_acc_if
// Beat input and result output handshakes of the accumulation stage.
//   in_valid_i / in_ready_o   : beat handshake
//   in_sum_i, in_exp_i        : signed partial sum and its block exponent
//   in_first_i, in_last_i     : group delimiters (may both be set)
//   out_valid_o / out_ready_i : result handshake
//   out_mant_o, out_exp_o     : signed accumulated mantissa and exponent
//   out_exp_ovf_o             : exponent saturated during the group
// Modports: master = beat producer / result consumer, slave = accumulator.
// -----------------------------------------------------------------------------
interface auteur_dotp_acc_if
  import auteur_pkg::*;
#(
  parameter int unsigned SumWidth = sum_width_default,
  parameter int unsigned AccWidth = acc_width_default,
  parameter int unsigned ExpWidth = exp_width_default
) ();

  logic                in_valid_i;
  logic                in_ready_o;
  logic [SumWidth-1:0] in_sum_i;
  logic [ExpWidth-1:0] in_exp_i;
  logic                in_first_i;
  logic                in_last_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [AccWidth-1:0] out_mant_o;
  logic [ExpWidth-1:0] out_exp_o;
  logic                out_exp_ovf_o;

  modport master (
    output in_valid_i, in_sum_i, in_exp_i, in_first_i, in_last_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_mant_o, out_exp_o, out_exp_ovf_o
  );

  modport slave (
    input  in_valid_i, in_sum_i, in_exp_i, in_first_i, in_last_i, out_ready_i,
    output in_ready_o, out_valid_o, out_mant_o, out_exp_o, out_exp_ovf_o
  );

endinterface

// File: rtl/auteur_align_add.sv
// -----------------------------------------------------------------------------
// auteur_align_add
// Combinational align / add / renormalise / saturate step of the accumulator.
//   acc_mant_i, acc_exp_i : current accumulator (signed mantissa, exponent)
//   in_sum_i, in_exp_i    : incoming partial sum and exponent
//   load_i                : bypass the add and load the sign-extended input
//   res_mant_o, res_exp_o : next accumulator value
//   res_sat_o             : exponent saturated on this step
// The operand with the smaller exponent is shifted right arithmetically (floor,
// no rounding) to the larger exponent. A carry into the guard bit is absorbed
// by a single right shift and an exponent increment.
// -----------------------------------------------------------------------------
module auteur_align_add
  import auteur_pkg::*;
#(
  parameter int unsigned SumWidth = sum_width_default,
  parameter int unsigned AccWidth = acc_width_default,
  parameter int unsigned ExpWidth = exp_width_default
) (
  input  logic signed [AccWidth-1:0] acc_mant_i,
  input  logic signed [ExpWidth-1:0] acc_exp_i,
  input  logic signed [SumWidth-1:0] in_sum_i,
  input  logic signed [ExpWidth-1:0] in_exp_i,
  input  logic                       load_i,
  output logic signed [AccWidth-1:0] res_mant_o,
  output logic signed [ExpWidth-1:0] res_exp_o,
  output logic                       res_sat_o
);

  typedef logic signed [ExpWidth:0] exp_ext_t;
  typedef logic        [ExpWidth:0] shift_t;
  typedef logic signed [AccWidth:0] sum_ext_t;

  // Shifts at or beyond the mantissa width leave only the sign.
  localparam shift_t ShiftLimit = shift_t'(AccWidth);

  logic signed [AccWidth-1:0] in_ext;
  exp_ext_t                   exp_diff;
  shift_t                     shift_amt;
  logic signed [AccWidth-1:0] op_acc;
  logic signed [AccWidth-1:0] op_in;
  logic signed [ExpWidth-1:0] base_exp;
  sum_ext_t                   sum;
  logic                       sum_ovf;

  assign in_ext = AccWidth'(in_sum_i);

  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // through this block leaves a value held, which would infer a latch.
    exp_diff   = exp_ext_t'(in_exp_i) - exp_ext_t'(acc_exp_i);
    shift_amt  = '0;
    op_acc     = acc_mant_i;
    op_in      = in_ext;
    base_exp   = in_exp_i;
    sum        = '0;
    sum_ovf    = 1'b0;
    res_mant_o = in_ext;
    res_exp_o  = in_exp_i;
    res_sat_o  = 1'b0;

    // Shift selection kept in if/else rather than ?: so the sign fill stays
    // arithmetic (a concatenation arm would make the whole expression unsigned).
    if (!exp_diff[ExpWidth]) begin
      shift_amt = shift_t'(exp_diff);
      base_exp  = in_exp_i;
      if (shift_amt >= ShiftLimit) begin
        op_acc = {AccWidth{acc_mant_i[AccWidth-1]}};
      end else begin
        op_acc = acc_mant_i >>> shift_amt;
      end
    end else begin
      shift_amt = shift_t'(-exp_diff);
      base_exp  = acc_exp_i;
      if (shift_amt >= ShiftLimit) begin
        op_in = {AccWidth{in_ext[AccWidth-1]}};
      end else begin
        op_in = in_ext >>> shift_amt;
      end
    end

    sum     = sum_ext_t'(op_acc) + sum_ext_t'(op_in);
    // Guard bit disagreeing with the mantissa sign bit means the add overflowed.
    sum_ovf = sum[AccWidth] ^ sum[AccWidth-1];

    if (!load_i) begin
      if (sum_ovf) begin
        res_mant_o = sum[AccWidth:1];
      end else begin
        res_mant_o = sum[AccWidth-1:0];
      end
      res_exp_o = ExpWidth'(renorm_exp(32'(base_exp), sum_ovf, ExpWidth));
      res_sat_o = renorm_sat(32'(base_exp), sum_ovf, ExpWidth);
    end
  end

endmodule

// File: rtl/auteur_dotp_acc.sv
// -----------------------------------------------------------------------------
// auteur_dotp_acc
// Accumulates the aligned partial dot products of one group (K-chunk sequence)
// and hands the mantissa/exponent result to normalisation through a single
// registered valid/ready stage.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : auteur_dotp_acc_if.slave (beat input, result output)
// A beat marked first, or any beat while no group is open, loads the
// accumulator; other beats align-add. The last beat's result goes to the
// output register. Input is stalled only while an unconsumed result is held.
// -----------------------------------------------------------------------------
module auteur_dotp_acc
  import auteur_pkg::*;
#(
  parameter int unsigned SumWidth = sum_width_default,
  parameter int unsigned AccWidth = acc_width_default,
  parameter int unsigned ExpWidth = exp_width_default
) (
  input logic             clk_i,
  input logic             rst_ni,
  auteur_dotp_acc_if.slave bus
);

  out_state_e                 state_q, state_d;
  logic signed [AccWidth-1:0] acc_mant_q, acc_mant_d;
  logic signed [ExpWidth-1:0] acc_exp_q, acc_exp_d;
  logic                       acc_open_q, acc_open_d;
  logic                       ovf_q, ovf_d;
  logic signed [AccWidth-1:0] out_mant_q, out_mant_d;
  logic signed [ExpWidth-1:0] out_exp_q, out_exp_d;
  logic                       out_ovf_q, out_ovf_d;

  logic                       in_ready;
  logic                       in_accept;
  logic                       last_accept;
  logic                       load;
  logic signed [AccWidth-1:0] res_mant;
  logic signed [ExpWidth-1:0] res_exp;
  logic                       res_sat;
  logic                       group_ovf;

  // Ready is also applied to non-last beats; only a held result can stall.
  assign in_ready    = (state_q == OUT_EMPTY) || bus.out_ready_i;
  assign in_accept   = bus.in_valid_i && in_ready;
  assign last_accept = in_accept && bus.in_last_i;
  assign load        = bus.in_first_i || !acc_open_q;
  // A load starts a fresh group, so the earlier saturation history is dropped.
  assign group_ovf   = (load ? 1'b0 : ovf_q) | res_sat;

  auteur_align_add #(
    .SumWidth (SumWidth),
    .AccWidth (AccWidth),
    .ExpWidth (ExpWidth)
  ) u_align_add (
    .acc_mant_i (acc_mant_q),
    .acc_exp_i  (acc_exp_q),
    .in_sum_i   (bus.in_sum_i),
    .in_exp_i   (bus.in_exp_i),
    .load_i     (load),
    .res_mant_o (res_mant),
    .res_exp_o  (res_exp),
    .res_sat_o  (res_sat)
  );

  // Accumulator and output data next-state.
  always_comb begin
    acc_mant_d = acc_mant_q;
    acc_exp_d  = acc_exp_q;
    acc_open_d = acc_open_q;
    ovf_d      = ovf_q;
    out_mant_d = out_mant_q;
    out_exp_d  = out_exp_q;
    out_ovf_d  = out_ovf_q;

    if (in_accept) begin
      acc_mant_d = res_mant;
      acc_exp_d  = res_exp;
      ovf_d      = group_ovf;
      acc_open_d = !bus.in_last_i;
      if (bus.in_last_i) begin
        out_mant_d = res_mant;
        out_exp_d  = res_exp;
        out_ovf_d  = group_ovf;
      end
    end
  end

  // Output occupancy FSM. In FULL an accepted beat implies out_ready_i, so a
  // coinciding last beat refills the register in the cycle it drains.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OUT_EMPTY: if (last_accept) state_d = OUT_FULL;
      OUT_FULL:  if (bus.out_ready_i && !last_accept) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the datapath registers are reset along with the control: the
      // output bus must read zero after reset and no partial group may survive.
      state_q    <= OUT_EMPTY;
      acc_mant_q <= '0;
      acc_exp_q  <= '0;
      acc_open_q <= 1'b0;
      ovf_q      <= 1'b0;
      out_mant_q <= '0;
      out_exp_q  <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values its
      // peers held before the edge, independent of statement order.
      state_q    <= state_d;
      acc_mant_q <= acc_mant_d;
      acc_exp_q  <= acc_exp_d;
      acc_open_q <= acc_open_d;
      ovf_q      <= ovf_d;
      out_mant_q <= out_mant_d;
      out_exp_q  <= out_exp_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign bus.in_ready_o    = in_ready;
  assign bus.out_valid_o   = (state_q == OUT_FULL);
  assign bus.out_mant_o    = out_mant_q;
  assign bus.out_exp_o     = out_exp_q;
  assign bus.out_exp_ovf_o = out_ovf_q;

endmodule

// File: tb/tb_auteur_dotp_acc.sv
// -----------------------------------------------------------------------------
// tb_auteur_dotp_acc
// Self-checking bench for auteur_dotp_acc. Directed group scenarios are
// followed by randomized groups under random output backpressure. A beat-level
// reference model built on plain integer arithmetic predicts each group result
// into a queue; a monitor compares the held output against the queue head on
// every cycle the output is valid and pops on the output handshake.
// -----------------------------------------------------------------------------
module tb_auteur_dotp_acc;
  import auteur_pkg::*;

  localparam int SW = 24;
  localparam int AW = 32;
  localparam int EW = 10;

  localparam longint MANT_MAX = (64'sd1 <<< (AW - 1)) - 64'sd1;
  localparam longint MANT_MIN = -(64'sd1 <<< (AW - 1));
  localparam int     EXP_TOP  = (1 <<< (EW - 1)) - 1;

  typedef struct {
    longint mant;
    int     exp;
    bit     ovf;
  } result_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  auteur_dotp_acc_if #(.SumWidth(SW), .AccWidth(AW), .ExpWidth(EW)) bus ();

  auteur_dotp_acc #(.SumWidth(SW), .AccWidth(AW), .ExpWidth(EW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int total    = 0;
  int bad      = 0;
  int n_pushed = 0;
  int n_seen   = 0;

  result_t exp_q[$];

  // Reference model state (beat level).
  longint m_mant = 0;
  int     m_exp  = 0;
  bit     m_ovf  = 1'b0;
  bit     m_open = 1'b0;

  // Output-ready control: forced value or a fresh random bit every cycle.
  bit rand_ready  = 1'b0;
  bit ready_force = 1'b1;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Division by 2**sh rounded toward minus infinity.
  function automatic longint floor_div_pow2(input longint v, input int sh);
    longint d;
    longint q;
    if (sh > 40) sh = 40;
    d = longint'(1) << sh;
    q = v / d;
    if (v < 0 && q * d != v) q = q - 1;
    return q;
  endfunction

  function automatic void model_beat(input longint sum, input int e, input bit first, input bit last);
    longint a;
    longint b;
    longint s;
    int     ne;
    result_t r;
    if (first || !m_open) begin
      m_mant = sum;
      m_exp  = e;
      m_ovf  = 1'b0;
    end else begin
      if (e >= m_exp) begin
        a  = floor_div_pow2(m_mant, e - m_exp);
        b  = sum;
        ne = e;
      end else begin
        a  = m_mant;
        b  = floor_div_pow2(sum, m_exp - e);
        ne = m_exp;
      end
      s = a + b;
      if (s > MANT_MAX || s < MANT_MIN) begin
        s  = floor_div_pow2(s, 1);
        ne = ne + 1;
        if (ne > EXP_TOP) begin
          ne    = EXP_TOP;
          m_ovf = 1'b1;
        end
      end
      m_mant = s;
      m_exp  = ne;
    end
    m_open = !last;
    if (last) begin
      r.mant = m_mant;
      r.exp  = m_exp;
      r.ovf  = m_ovf;
      exp_q.push_back(r);
      n_pushed++;
    end
  endfunction

  // Present one beat (call just after a rising edge); returns just after the
  // edge that accepted it.
  task automatic send_beat(input longint sum, input int e, input bit first, input bit last);
    int waited   = 0;
    bit accepted = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.in_sum_i   = sum[SW-1:0];
    bus.in_exp_i   = e[EW-1:0];
    bus.in_first_i = first;
    bus.in_last_i  = last;
    while (!accepted && waited <= 100) begin
      @(negedge clk);
      if (bus.in_ready_o) accepted = 1'b1;
      else waited++;
    end
    if (accepted) model_beat(sum, e, first, last);
    else check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic check_out(input string name, input longint mant, input int e, input bit ovf);
    check({name, "_valid"}, longint'(bus.out_valid_o), 1);
    check({name, "_mant"}, longint'($signed(bus.out_mant_o)), mant);
    check({name, "_exp"}, longint'($signed(bus.out_exp_o)), longint'(e));
    check({name, "_ovf"}, longint'(bus.out_exp_ovf_o), longint'(ovf));
  endtask

  // Sole driver of out_ready_i; changes land 2 time units after a rising edge.
  initial begin
    bus.out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("in_ready_rule", longint'(bus.in_ready_o),
              longint'(!bus.out_valid_o || bus.out_ready_i));
        if (bus.out_valid_o) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_output", longint'(exp_q.size()), 1);
          end else begin
            check("sb_mant", longint'($signed(bus.out_mant_o)), exp_q[0].mant);
            check("sb_exp", longint'($signed(bus.out_exp_o)), longint'(exp_q[0].exp));
            check("sb_ovf", longint'(bus.out_exp_ovf_o), longint'(exp_q[0].ovf));
            if (bus.out_ready_i) begin
              void'(exp_q.pop_front());
              n_seen++;
            end
          end
        end
      end
    end
  end

  initial begin
    int     len;
    int     e;
    bit     first;
    int     waited;
    logic [SW-1:0] r;
    longint sum;

    bus.in_valid_i = 1'b0;
    bus.in_sum_i   = '0;
    bus.in_exp_i   = '0;
    bus.in_first_i = 1'b0;
    bus.in_last_i  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", longint'(bus.in_ready_o), 1);
    check("rst_out_valid", longint'(bus.out_valid_o), 0);
    check("rst_out_mant", longint'(bus.out_mant_o), 0);
    check("rst_out_exp", longint'(bus.out_exp_o), 0);
    check("rst_out_ovf", longint'(bus.out_exp_ovf_o), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-beat group, result one edge after acceptance.
    send_beat(-5, 3, 1'b1, 1'b1);
    check_out("single", -5, 3, 1'b0);
    @(posedge clk);
    #1;
    check("single_drained", longint'(bus.out_valid_o), 0);

    // Two-beat group: 100@0 aligned to exponent 1 becomes 50.
    send_beat(100, 0, 1'b1, 1'b0);
    send_beat(100, 1, 1'b0, 1'b1);
    check_out("pair", 150, 1, 1'b0);

    // Shift past the mantissa width leaves only the sign.
    send_beat(1000, 0, 1'b1, 1'b0);
    send_beat(1, 40, 1'b0, 1'b1);
    check_out("wide_pos", 1, 40, 1'b0);
    send_beat(-1000, 0, 1'b1, 1'b0);
    send_beat(1, 40, 1'b0, 1'b1);
    check_out("wide_neg", 0, 40, 1'b0);

    // Mantissa overflow renormalises once.
    for (int i = 0; i < 257; i++) send_beat(8388607, 0, i == 0, i == 256);
    check_out("mant_ovf", 1077935999, 1, 1'b0);

    // Same at the top exponent: exponent saturates and the flag is raised.
    for (int i = 0; i < 257; i++) send_beat(8388607, 511, i == 0, i == 256);
    check_out("exp_sat", 1077935999, 511, 1'b1);

    // Next group starts with a clean flag.
    send_beat(3, 5, 1'b1, 1'b1);
    check_out("ovf_cleared", 3, 5, 1'b0);

    // Backpressure: held result stalls a second last beat.
    @(posedge clk);
    #1;
    ready_force = 1'b0;
    @(posedge clk);
    #3;
    send_beat(11, 2, 1'b1, 1'b1);
    check_out("bp_first", 11, 2, 1'b0);
    fork
      send_beat(22, 4, 1'b1, 1'b1);
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready_low", longint'(bus.in_ready_o), 0);
        check("bp_held_mant", longint'($signed(bus.out_mant_o)), 11);
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        @(negedge clk);
        check("bp_in_ready_high", longint'(bus.in_ready_o), 1);
        check("bp_out_valid_same_cycle", longint'(bus.out_valid_o), 1);
      end
    join
    check_out("bp_second", 22, 4, 1'b0);
    @(posedge clk);
    #1;

    // Reset mid-group: partial sum discarded, next beat loads fresh.
    send_beat(50, 0, 1'b1, 1'b0);
    send_beat(60, 0, 1'b0, 1'b0);
    rst_n  = 1'b0;
    m_open = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", longint'(bus.out_valid_o), 0);
    check("midrst_out_mant", longint'(bus.out_mant_o), 0);
    check("midrst_out_exp", longint'(bus.out_exp_o), 0);
    check("midrst_in_ready", longint'(bus.in_ready_o), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(7, 2, 1'b0, 1'b1);
    check_out("post_rst_load", 7, 2, 1'b0);

    // Randomized groups under random output backpressure.
    rand_ready = 1'b1;
    for (int g = 0; g < 60; g++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        r   = SW'($urandom);
        sum = longint'($signed(r));
        if ($urandom_range(0, 7) == 0) e = int'($urandom_range(0, 1023)) - 512;
        else e = int'($urandom_range(0, 40)) - 20;
        first = (b == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
        send_beat(sum, e, first, b == len - 1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    @(posedge clk);
    #1;
    rand_ready  = 1'b0;
    ready_force = 1'b1;

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check("sb_drained", longint'(exp_q.size()), 0);
    check("results_seen", longint'(n_seen), longint'(n_pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/auteur_dotp_acc.md
# auteur_dotp_acc

Accumulation stage directly downstream of the scaled dot-product datapath. It consumes one aligned partial dot product per beat, each carrying its block exponent, and accumulates beats of a group (one K-chunk sequence) into a wide signed accumulator with exponent alignment and single-bit renormalisation. On the group's last beat it emits the accumulated mantissa/exponent pair to the normalisation stage through a registered valid/ready output.

## Interface
- `SumWidth`, 24: width of incoming signed partial sum.
- `AccWidth`, 32: width of signed accumulator mantissa; must be > `SumWidth`.
- `ExpWidth`, 10: width of signed exponent (input and output).
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `in_valid_i` in 1: input beat valid.
- `in_ready_o` out 1: input beat accepted when high with `in_valid_i`.
- `in_sum_i` in `SumWidth`: signed partial sum, two's complement.
- `in_exp_i` in `ExpWidth`: signed exponent of `in_sum_i`.
- `in_first_i` in 1: beat opens a group.
- `in_last_i` in 1: beat closes a group (may coincide with `in_first_i`).
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: downstream accepts result.
- `out_mant_o` out `AccWidth`: signed accumulated mantissa.
- `out_exp_o` out `ExpWidth`: signed exponent of `out_mant_o`.
- `out_exp_ovf_o` out 1: exponent saturated at least once during the group.

## Operation
- State: `acc_mant_q`, `acc_exp_q`, `acc_open_q`, `ovf_q`; output register `out_*_q` + `out_valid_q`.
- Beat with `in_first_i`, or any beat while `acc_open_q`=0: the accumulator is loaded with `in_sum_i` sign-extended and `in_exp_i`; `ovf` cleared. No add.
- Other beats: align-add. `d = in_exp_i - acc_exp_q` computed at `ExpWidth+1` bits. If `d >= 0`: exponent = `in_exp_i`, accumulator arithmetically shifted right by `d`. Else: exponent = `acc_exp_q`, input shifted right by `-d`. Shift amounts ≥ `AccWidth` yield pure sign (0 or -1). Truncation toward −∞; no rounding or sticky bit.
- Sum formed at `AccWidth+1` bits. If the top two bits differ (overflow), result = sum >>> 1 truncated to `AccWidth`, exponent + 1.
- Exponent increment past max signed value saturates at max and sets `ovf`.
- `acc_open_q` set on every accepted non-last beat, cleared on an accepted last beat.
- Accepted last beat: align-add result (or load result) written to the output register, `out_valid_q` set, `out_exp_ovf_o` = group `ovf`.
- `in_ready_o = !out_valid_q || out_ready_i` for every beat, including non-last beats (simplifies control).
- FSM (2 states, on output side): EMPTY → FULL on an accepted last beat. FULL → EMPTY on `out_ready_i` with no new last beat. FULL → FULL when handshake and last beat coincide.

## Timing
- Reset values: `in_ready_o`=1, `out_valid_o`=0, `out_mant_o`=0, `out_exp_o`=0, `out_exp_ovf_o`=0; accumulator cleared, `acc_open_q`=0.
- Latency: a last beat accepted at edge t gives `out_valid_o`=1 after edge t. One registered stage, consistent with `dotp_pipe_cfg_t.accumulation`=1.
- Throughput: one beat per cycle. A result can be consumed in the same cycle that the next group's last beat is accepted.
- Output data remains stable while `out_valid_o && !out_ready_i`.
- Reset mid-group discards the partial accumulation. The first beat after reset is treated as a group opener.

## Structure
- Add to `auteur_pkg`: `acc_width_default`/`exp_width_default` localparams and a function that computes the renormalised exponent with saturation.
- Sub-module `auteur_align_add` (combinational): align, add, renormalise, saturate. The top level holds the registers, handshake and FSM.

## Test plan
- Single beat (sum=-5, exp=3, first&last) → out_mant=-5, out_exp=3, ovf=0, one cycle later.
- Group (100, exp 0, first), (100, exp 1, last) → out_mant=150, out_exp=1.
- Wide shift: (1000, exp 0, first), (1, exp 40, last) → out 1, exp 40. Same test with -1000 → out 0, exp 40.
- Overflow: 257 beats of 8388607 at exp 0 → out_mant=1077935999, out_exp=1.
- Exponent saturation: acc exp 511 with overflow → out_exp=511, out_exp_ovf_o=1.
- Backpressure: hold out_ready_i=0 while a second last beat is presented → in_ready_o=0 and output stable. Raise out_ready_i → both handshakes occur in the same cycle. Also assert rst_ni mid-group → outputs reach reset values and the next beat loads fresh.
